nes_pad_reader: RTL and testbench

//  Polls a standard NES controller over its latch/clock/data serial interface at a fixed rate.

---
 rtl/nes_pad_reader_pkg.sv | 18 +
 rtl/nes_pad_reader_if.sv | 17 +
 rtl/nes_pad_reader_tick_gen.sv | 27 ++
 rtl/nes_pad_reader.sv | 114 +++++++++++
 tb/tb_nes_pad_reader.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/nes_pad_reader_pkg.sv
// Shared types and constants for the NES controller poller.
package nes_pkg;

  typedef enum logic [2:0] {IDLE, LATCH, LWAIT, CLKHI, CLKLO, DONE} state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int LATCH_TICKS = 2;
  localparam int NUM_BUTTONS = 8;

endpackage

// File: rtl/nes_pad_reader_if.sv
// Controller pins plus the decoded button outputs of the poller.
interface nes_pad_reader_if;
  import nes_pkg::*;

  logic                   nes_data;
  logic                   nes_latch;
  logic                   nes_clk;
  logic [NUM_BUTTONS-1:0] buttons;
  logic                   valid;
  logic [NUM_BUTTONS-1:0] btn_press;
  state_t                 state;

  // valid is a one-cycle strobe with no ready: buttons/btn_press are new in that cycle and buttons holds after.
  modport master (input nes_data, output nes_latch, nes_clk, buttons, valid, btn_press, state);
  modport slave  (output nes_data, input nes_latch, nes_clk, buttons, valid, btn_press, state);

endinterface

// File: rtl/nes_pad_reader_tick_gen.sv
// Serial half-period divider; tick_last marks the final clk cycle of each tick.
module nes_tick_gen #(
  parameter int TICK_DIV = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick_last
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_last = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick_last) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller poller: latch/clock/data frame at a fixed rate, registered button vector.
// Optional NES_EDGE_DETECT_EN builds the newly-pressed (btn_press) logic.
module nes_pad_reader import nes_pkg::*; #(
  parameter int TICK_DIV = 300,
  parameter int POLL_DIV = 833_333
) (
  input logic              clk,
  input logic              reset,
  nes_pad_reader_if.master bus
);

  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  state_t                 state_q, state_d;
  logic [PW-1:0]          poll_q, poll_d;
  logic                   poll_wrap;
  logic [1:0]             lticks_q, lticks_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [NUM_BUTTONS-1:0] shift_q, shift_d;
  logic [NUM_BUTTONS-1:0] buttons_q;
  logic                   sync_q, latch_q, nclk_q, valid_q;
  logic                   tick_last, restart;

  nes_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .tick_last (tick_last)
  );

  assign poll_wrap = (poll_q == PW'(POLL_DIV - 1));
  assign poll_d    = poll_wrap ? '0 : poll_q + PW'(1);
  assign restart   = (state_d != state_q);

  always_comb begin
    state_d   = state_q;
    lticks_d  = lticks_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE:  if (poll_wrap) state_d = LATCH;
      LATCH: if (tick_last) begin
               if (lticks_q == 2'(LATCH_TICKS - 1)) state_d = LWAIT;
               else lticks_d = lticks_q + 2'd1;
             end
      LWAIT: if (tick_last) begin
               shift_d[0] = ~sync_q;
               bit_idx_d  = 3'd1;
               state_d    = CLKHI;
             end
      CLKHI: if (tick_last) state_d = CLKLO;
      CLKLO: if (tick_last) begin
               shift_d[bit_idx_q] = ~sync_q;
               if (bit_idx_q == 3'd7) state_d = DONE;
               else begin
                 bit_idx_d = bit_idx_q + 3'd1;
                 state_d   = CLKHI;
               end
             end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) lticks_d = '0;
  end

  // sync_q is the dedicated metastability stage; the shift-register bit that samples it is the second.
  // One dedicated stage keeps the pin-to-sample latency within a single tick at TICK_DIV=1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      poll_q    <= '0;
      lticks_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      sync_q    <= 1'b1;
      latch_q   <= 1'b0;
      nclk_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      poll_q    <= poll_d;
      lticks_q  <= lticks_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      sync_q    <= bus.nes_data;
      latch_q   <= (state_d == LATCH);
      nclk_q    <= (state_d == CLKHI);
      valid_q   <= (state_q == DONE);
      if (state_q == DONE) buttons_q <= shift_q;
    end
  end

`ifdef NES_EDGE_DETECT_EN
  logic [NUM_BUTTONS-1:0] press_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                press_q <= '0;
    else if (state_q == DONE) press_q <= shift_q & ~buttons_q;
    else                      press_q <= '0;
  end
  assign bus.btn_press = press_q;
`else
  assign bus.btn_press = '0;
`endif

  assign bus.nes_latch = latch_q;
  assign bus.nes_clk   = nclk_q;
  assign bus.buttons   = buttons_q;
  assign bus.valid     = valid_q;
  assign bus.state     = state_q;

  a_wrap_in_idle: assert property (@(posedge clk) disable iff (reset) poll_wrap |-> state_q == IDLE);

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: two instances (TICK_DIV=4 and 1) polled by behavioural pad models.
module tb_nes_pad_reader;
  import nes_pkg::*;

  localparam int TA = 4;
  localparam int TB = 1;
  localparam int PD = 200;
  localparam int FRAME_TICKS = LATCH_TICKS + 1 + 2 * (NUM_BUTTONS - 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nes_pad_reader_if bus4 ();
  nes_pad_reader_if bus1 ();

  nes_pad_reader #(.TICK_DIV(TA), .POLL_DIV(PD)) dut4 (.clk(clk), .reset(reset), .bus(bus4.master));
  nes_pad_reader #(.TICK_DIV(TB), .POLL_DIV(PD)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [7:0] pat = 8'h00;
  logic [7:0] btn_model = 8'h00;
  logic tog_en = 1'b0;

  // clock/reset bookkeeping: cyc == k after the k-th edge following reset release
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // pad models: reload on latch, shift on nes_clk rise, output active-low
  int idx4 = 8;
  int idx1 = 8;
  always @(posedge bus4.nes_clk or posedge bus4.nes_latch)
    if (bus4.nes_latch) idx4 = 0; else idx4 = idx4 + 1;
  always @(posedge bus1.nes_clk or posedge bus1.nes_latch)
    if (bus1.nes_latch) idx1 = 0; else idx1 = idx1 + 1;

  int   since4 = 1000;
  int   ph4 = 0;
  logic pl4 = 1'b0;
  logic pc4 = 1'b0;
  logic hold4;
  always @(posedge clk) begin
    #1;
    if (bus4.nes_latch && !pl4)    begin ph4 = 1; since4 = 0; end
    else if (bus4.nes_clk && !pc4) begin ph4 = 2; since4 = 0; end
    else if (since4 < 1000)        since4++;
    pl4 = bus4.nes_latch;
    pc4 = bus4.nes_clk;
    hold4 = (ph4 == 1 && since4 >= 2*TA + 1 && since4 <= 3*TA - 1) ||
            (ph4 == 2 && since4 >= 2*TA - 3 && since4 <= 2*TA - 1);
    if (tog_en && !hold4) bus4.nes_data = ~bus4.nes_data;
    else                  bus4.nes_data = (idx4 < 8) ? ~pat[idx4] : 1'b1;
    bus1.nes_data = (idx1 < 8) ? ~pat[idx1] : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // reference waveform from the frame rules, t = cycles since latch rise
  task automatic chk_inst(input string nm, input int t, input int tk,
                          input logic l, input logic k, input logic v,
                          input logic [7:0] b, input logic [7:0] bp,
                          input logic [7:0] p, input logic [7:0] old, input logic [7:0] pe);
    int done_t;
    logic el, ek, ev;
    done_t = FRAME_TICKS * tk + 1;
    el = (t >= 0) && (t < LATCH_TICKS * tk);
    ek = (t >= 3 * tk) && (t < FRAME_TICKS * tk) && (((t - 3 * tk) / tk) % 2 == 0);
    ev = (t == done_t);
    chk({nm, "_latch"},   {7'd0, l},     {7'd0, el});
    chk({nm, "_nesclk"},  {7'd0, k},     {7'd0, ek});
    chk({nm, "_overlap"}, {7'd0, l & k}, 8'h00);
    chk({nm, "_valid"},   {7'd0, v},     {7'd0, ev});
    chk({nm, "_buttons"}, b,  (t >= done_t) ? p : old);
    chk({nm, "_press"},   bp, (t == done_t) ? pe : 8'h00);
  endtask

  task automatic check_frame(input int f, input logic [7:0] p, input int last_t);
    logic [7:0] old, pe;
    old = btn_model;
`ifdef NES_EDGE_DETECT_EN
    pe = p & ~old;
`else
    pe = 8'h00;
`endif
    for (int c = f - 2; c <= f + last_t; c++) begin
      goto(c);
      chk_inst("t4", c - f, TA, bus4.nes_latch, bus4.nes_clk, bus4.valid,
               bus4.buttons, bus4.btn_press, p, old, pe);
      chk_inst("t1", c - f, TB, bus1.nes_latch, bus1.nes_clk, bus1.valid,
               bus1.buttons, bus1.btn_press, p, old, pe);
    end
    if (last_t > FRAME_TICKS * TA) btn_model = p;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_latch4"}, {7'd0, bus4.nes_latch}, 8'h00);
    chk({nm, "_clk4"},   {7'd0, bus4.nes_clk},   8'h00);
    chk({nm, "_valid4"}, {7'd0, bus4.valid},     8'h00);
    chk({nm, "_btn4"},   bus4.buttons,           8'h00);
    chk({nm, "_press4"}, bus4.btn_press,         8'h00);
    chk({nm, "_state4"}, {5'd0, bus4.state},     {5'd0, IDLE});
    chk({nm, "_latch1"}, {7'd0, bus1.nes_latch}, 8'h00);
    chk({nm, "_valid1"}, {7'd0, bus1.valid},     8'h00);
    chk({nm, "_btn1"},   bus1.buttons,           8'h00);
    chk({nm, "_state1"}, {5'd0, bus1.state},     {5'd0, IDLE});
  endtask

  localparam int FULL = FRAME_TICKS * TA + 3;

  initial begin
    int f;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    reset = 1'b0;

    // idle pad, then A+Up held for two frames, then Right added
    check_frame(200, pat, FULL);
    goto(300);  pat = 8'h11;
    check_frame(400, pat, FULL);
    check_frame(600, pat, FULL);
    goto(700);  pat = 8'h91;
    check_frame(800, pat, FULL);
    check_frame(1000, pat, FULL);

    // random patterns, then random patterns with data toggling outside sample windows
    f = 1200;
    for (int i = 0; i < 6; i++) begin
      goto(f - 100);
      pat = 8'($urandom_range(0, 255));
      if (i == 3) tog_en = 1'b1;
      check_frame(f, pat, FULL);
      f += PD;
    end

    // reset while the TICK_DIV=4 instance is in CLKHI of bit 4
    goto(f - 100);
    tog_en = 1'b0;
    pat = 8'($urandom_range(1, 255));
    check_frame(f, pat, 3*TA + 2*3*TA + 1);
    chk("mid_clkhi4", {7'd0, bus4.nes_clk}, 8'h01);
    reset = 1'b1;
    #1;
    chk_reset_state("midrst");
    btn_model = 8'h00;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_hold_valid4", {7'd0, bus4.valid}, 8'h00);
    end
    reset = 1'b0;
    check_frame(200, pat, FULL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
